accelerator: RTL and testbench

Matrix-multiply accelerator built around an ARR_SIZE×ARR_SIZE output-stationary systolic array of signed 8-bit multiply/32-bit accumulate processing elements. A host streams 64-bit command words in to load operand matrices A and B and to start a product C = A×B. The host then drains the 16 (ARR_SIZE²) 32-bit results one at a time through a result buffer. This block is the top level of the compute datapath.

---
 rtl/accel_pkg.sv | 27 ++
 rtl/accel_pe.sv | 42 ++++
 rtl/accelerator.sv | 178 +++++++++++++++++
 tb/tb_accelerator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the systolic matrix-multiply accelerator:
// command field positions, opcodes, datapath widths and FSM states.
package accel_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 2 * DATA_W;

  // Command word field positions
  localparam int OPC_MSB = 63;
  localparam int OPC_LSB = 60;
  localparam int IDX_MSB = 51;
  localparam int IDX_LSB = 48;

  // Opcodes; every other value is a NOP
  localparam logic [3:0] OP_LOAD_A  = 4'h1;
  localparam logic [3:0] OP_LOAD_B  = 4'h2;
  localparam logic [3:0] OP_COMPUTE = 4'h3;
  localparam logic [3:0] OP_CLEAR   = 4'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/accel_pe.sv
// Output-stationary processing element: signed 8x8 multiply into a
// wrapping 32-bit accumulator, with registered east/south operand hand-off.
module accel_pe
  import accel_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] a_o,
  output logic signed [DATA_W-1:0] b_o,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod = a_i * b_i;

  // Accumulate while enabled; operands always move one PE east/south.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (en_i) begin
        acc_q <= acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/accelerator.sv
// Matrix-multiply accelerator top: command decode, operand register files,
// skewed edge feeds into an N x N PE array, FSM, result buffer and the
// synchronized host drain strobe.
module accelerator
  import accel_pkg::*;
#(
  parameter int ARR_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        external_clk,
  input  logic [63:0] accelerator_input,
  output logic [31:0] accelerator_output,
  output logic        buffer_full
);

  localparam int N      = ARR_SIZE;
  localparam int NN     = N * N;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int STEP_W = $clog2(3 * N);
  localparam int CNT_W  = $clog2(NN + 1);
  localparam int BUF_W  = $clog2(NN);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3 * N - 3);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    rd_pos;
  logic [ACC_W-1:0]    out_q;
  logic                full_q;
  logic [1:0]          sync_q;
  logic                prev_q;

  logic signed [DATA_W-1:0] a_q [N][N];
  logic signed [DATA_W-1:0] b_q [N][N];
  logic [ACC_W-1:0]         buf_q [NN];
  logic signed [ACC_W-1:0]  acc_w [NN];
  logic signed [DATA_W-1:0] a_h [N][N+1];
  logic signed [DATA_W-1:0] b_v [N+1][N];
  logic [N-1:0]             a_edge, b_edge;

  logic [3:0]       opcode, cmd_idx;
  logic [IDX_W-1:0] row_sel;
  logic idle, idx_ok, load_a, load_b, clear_cmd, compute_go;
  logic run, pe_clr, drain_edge, drain_go;

  assign opcode     = accelerator_input[OPC_MSB:OPC_LSB];
  assign cmd_idx    = accelerator_input[IDX_MSB:IDX_LSB];
  assign row_sel    = cmd_idx[IDX_W-1:0];
  assign idle       = (state_q == IDLE);
  assign run        = (state_q == RUN);
  assign idx_ok     = (cmd_idx < 4'(N));
  assign load_a     = idle && (opcode == OP_LOAD_A) && idx_ok;
  assign load_b     = idle && (opcode == OP_LOAD_B) && idx_ok;
  assign clear_cmd  = idle && (opcode == OP_CLEAR);
  assign compute_go = idle && (opcode == OP_COMPUTE) && (count_q == '0);
  assign pe_clr     = !rst || compute_go;

  // Next state: a COMPUTE walks 3N-2 feed steps, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: if (compute_go) begin
        state_d = RUN;
        step_d  = '0;
      end
      RUN: if (step_q == LAST_STEP) state_d = DONE;
           else step_d = step_q + 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and feed step registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      logic [STEP_W:0] a_m, b_m;
      // Row gi lags gi steps, so it needs A[gi][k-gi]; underflow lands >= N.
      assign a_m = {1'b0, step_q} - (STEP_W+1)'(gi);
      assign a_h[gi][0] = (run && a_m < (STEP_W+1)'(N)) ? a_q[gi][a_m[IDX_W-1:0]] : '0;
      // Column gi (same index range) needs B[k-gi][gi] on the north edge.
      assign b_m = {1'b0, step_q} - (STEP_W+1)'(gi);
      assign b_v[0][gi] = (run && b_m < (STEP_W+1)'(N)) ? b_q[b_m[IDX_W-1:0]][gi] : '0;
      assign a_edge[gi] = ^a_h[gi][N];
      assign b_edge[gi] = ^b_v[N][gi];

      for (gj = 0; gj < N; gj++) begin : g_col
        // Operand element: cleared by CLEAR, written by a matching LOAD.
        always_ff @(posedge clk) begin
          if (!rst || clear_cmd) begin
            a_q[gi][gj] <= '0;
            b_q[gi][gj] <= '0;
          end else begin
            if (load_a && row_sel == IDX_W'(gi))
              a_q[gi][gj] <= accelerator_input[DATA_W*gj +: DATA_W];
            if (load_b && row_sel == IDX_W'(gi))
              b_q[gi][gj] <= accelerator_input[DATA_W*gj +: DATA_W];
          end
        end

        // Result slot: snapshot of PE (gi,gj) taken in DONE, row-major.
        always_ff @(posedge clk) begin
          if (!rst || clear_cmd) buf_q[gi*N+gj] <= '0;
          else if (state_q == DONE) buf_q[gi*N+gj] <= acc_w[gi*N+gj];
        end

        accel_pe u_pe (
          .clk   (clk),
          .clr_i (pe_clr),
          .en_i  (run),
          .a_i   (a_h[gi][gj]),
          .b_i   (b_v[gi][gj]),
          .a_o   (a_h[gi][gj+1]),
          .b_o   (b_v[gi+1][gj]),
          .acc_o (acc_w[gi*N+gj])
        );
      end
    end
  endgenerate

  // Drain strobe: two-flop synchronizer plus an edge-detect flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], external_clk};
      prev_q <= sync_q[1];
    end
  end

  assign drain_edge = sync_q[1] && !prev_q;
  // CLEAR takes priority over a coincident drain; DONE never sees count > 0.
  assign drain_go   = drain_edge && (count_q != '0) && !clear_cmd && (state_q != DONE);
  assign rd_pos     = CNT_W'(NN) - count_q;

  // Result count: filled by DONE, emptied by CLEAR, decremented per drain.
  always_comb begin
    count_d = count_q;
    if (state_q == DONE)  count_d = CNT_W'(NN);
    else if (clear_cmd)   count_d = '0;
    else if (drain_go)    count_d = count_q - 1'b1;
  end

  // Count, full flag and drained output word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(NN));
      if (drain_go) out_q <= buf_q[rd_pos[BUF_W-1:0]];
    end
  end

  assign accelerator_output = out_q;
  assign buffer_full        = full_q;

  // Bits with no function in this configuration (ignored fields, array edges).
  logic unused_bits;
  assign unused_bits = ^{accelerator_input[59:52], accelerator_input[47:32],
                         accelerator_input[31:0], rd_pos, a_edge, b_edge};

endmodule

// File: tb/tb_accelerator.sv
// Randomized scoreboard bench for the accelerator: a matrix-level model
// predicts each drained result; a monitor compares at scheduled cycles.
module tb_accelerator;

  localparam int N  = 4;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        external_clk = 1'b0;
  logic [63:0] accelerator_input = '0;
  logic [31:0] accelerator_output;
  logic        buffer_full;

  accelerator #(.ARR_SIZE(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .external_clk       (external_clk),
    .accelerator_input  (accelerator_input),
    .accelerator_output (accelerator_output),
    .buffer_full        (buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    bit          chk_out;
    logic [31:0] out;
    bit          chk_full;
    bit          full;
    string       name;
  } item_t;

  item_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whole matrices and a list of pending results.
  int          ma[N][N];
  int          mb[N][N];
  logic [31:0] mres[NN];
  int          mcount = 0;
  logic [31:0] mlast  = '0;

  function automatic logic [63:0] mkword(input logic [3:0] op, input logic [3:0] idx,
                                         input logic [31:0] data);
    logic [7:0]  j1;
    logic [15:0] j2;
    j1 = 8'($urandom);
    j2 = 16'($urandom);
    return {op, j1, idx, j2, data};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    mcount = 0;
    mlast  = '0;
  endtask

  task automatic model_cmd(input logic [63:0] w);
    logic [3:0]        op, idx;
    logic signed [7:0] e;
    int                s;
    op  = w[63:60];
    idx = w[51:48];
    case (op)
      4'h1, 4'h2: if (idx < N) begin
        for (int j = 0; j < N; j++) begin
          e = w[8*j +: 8];
          if (op == 4'h1) ma[idx][j] = e;
          else            mb[idx][j] = e;
        end
      end
      4'h3: if (mcount == 0) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
            mres[i*N+j] = s;
          end
        mcount = NN;
      end
      4'h4: begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            ma[i][j] = 0;
            mb[i][j] = 0;
          end
        mcount = 0;
      end
      default: ;
    endcase
  endtask

  task automatic push(input int due, input bit co, input logic [31:0] o,
                      input bit cf, input bit f, input string nm);
    item_t it;
    it.due = due; it.chk_out = co; it.out = o; it.chk_full = cf; it.full = f; it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one command word for one clk edge.
  task automatic send(input logic [63:0] w);
    accelerator_input = w;
    model_cmd(w);
    tick(1);
    accelerator_input = '0;
  endtask

  task automatic do_compute(input string nm);
    int  p;
    bit  acc;
    bit  was_full;
    p        = cyc;
    acc      = (mcount == 0);
    was_full = (mcount == NN);
    send(mkword(4'h3, 4'($urandom), 32'($urandom)));
    push(p + 11, 1'b0, '0, 1'b1, acc ? 1'b0 : was_full, {nm, "_full_pre"});
    push(p + 12, 1'b0, '0, 1'b1, acc ? 1'b1 : was_full, {nm, "_full_post"});
    tick(12);
  endtask

  task automatic drain(input string nm);
    int p;
    p = cyc;
    external_clk = 1'b1;
    if (mcount > 0) begin
      mlast  = mres[NN - mcount];
      mcount = mcount - 1;
    end
    push(p + 3, 1'b1, mlast, 1'b1, (mcount == NN), nm);
    tick(2);
    external_clk = 1'b0;
    tick(2);
  endtask

  // Drain edge detected in the same cycle CLEAR is sampled.
  task automatic drain_clear();
    int p;
    p = cyc;
    external_clk = 1'b1;
    tick(2);
    send(mkword(4'h4, 4'($urandom), 32'($urandom)));
    push(p + 3, 1'b1, mlast, 1'b1, 1'b0, "drain_vs_clear");
    external_clk = 1'b0;
    tick(2);
  endtask

  task automatic drain_all(input string nm);
    while (mcount > 0) drain(nm);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    tick(2);
    rst = 1'b1;
    push(cyc + 1, 1'b1, '0, 1'b1, 1'b0, "reset_state");
  endtask

  task automatic load_rows(input logic [3:0] op, input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
    send(mkword(op, 4'd0, r0));
    send(mkword(op, 4'd1, r1));
    send(mkword(op, 4'd2, r2));
    send(mkword(op, 4'd3, r3));
  endtask

  // Monitor: compares every scoreboard entry whose cycle has come.
  initial begin
    int i;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < sbq.size()) begin
        if (sbq[i].due <= cyc) begin
          if (sbq[i].chk_out) begin
            n_checks++;
            if (accelerator_output !== sbq[i].out) begin
              n_fail++;
              $display("FAIL %s @%0d: accelerator_output=%h expected %h",
                       sbq[i].name, cyc, accelerator_output, sbq[i].out);
            end
          end
          if (sbq[i].chk_full) begin
            n_checks++;
            if (buffer_full !== sbq[i].full) begin
              n_fail++;
              $display("FAIL %s_flag @%0d: buffer_full=%b expected %b",
                       sbq[i].name, cyc, buffer_full, sbq[i].full);
            end
          end
          $display("[%0d] %s out=%h full=%b", cyc, sbq[i].name, accelerator_output, buffer_full);
          sbq.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    logic [3:0] op;
    model_reset();
    tick(1);

    // Reset, then drains with nothing buffered.
    apply_reset();
    tick(2);
    drain("drain_empty_after_reset");
    drain("drain_empty_after_reset");

    // NOP words leave everything untouched.
    send(64'hFFFF_FFFF_FFFF_FFFF);
    send(64'h0);
    send(64'hAAAA_AAAA_AAAA_AAAA);
    send(64'h5555_5555_5555_5555);
    push(cyc + 1, 1'b1, '0, 1'b1, 1'b0, "nop_words");
    tick(2);

    // Identity product: results 1..16 in row-major order.
    load_rows(4'h1, 32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000);
    load_rows(4'h2, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D);
    do_compute("identity");
    do_compute("compute_when_full");
    drain_all("identity_drain");

    // Extreme signed values.
    load_rows(4'h1, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080);
    load_rows(4'h2, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080);
    do_compute("neg_x_neg");
    drain_all("neg_x_neg_drain");
    load_rows(4'h2, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
    do_compute("neg_x_pos");
    repeat (5) drain("neg_x_pos_drain");
    do_compute("compute_when_nonempty");
    drain_all("neg_x_pos_rest");
    drain("drain_past_empty");
    send(mkword(4'h4, 4'd0, 32'h0));
    do_compute("compute_after_clear");
    drain_all("zero_drain");

    // Randomized rounds with junk fields, NOPs and out-of-range loads.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        send(mkword(4'h1, 4'(i), 32'($urandom)));
        send(mkword(4'h2, 4'(i), 32'($urandom)));
        op = 4'($urandom_range(5, 15));
        send(mkword(($urandom_range(0, 1) != 0) ? op : 4'h0, 4'($urandom), 32'($urandom)));
        send(mkword(4'($urandom_range(1, 2)), 4'($urandom_range(N, 15)), 32'($urandom)));
      end
      do_compute("rand_compute");
      d = $urandom_range(1, NN - 1);
      repeat (d) drain("rand_drain");
      if (r % 2 == 1) begin
        drain_clear();
        drain("drain_after_clear");
      end else begin
        drain_all("rand_drain_rest");
      end
    end

    // Reset during RUN step 3 aborts the product.
    load_rows(4'h1, 32'h0102_0304, 32'h0506_0708, 32'h0102_0304, 32'h0506_0708);
    load_rows(4'h2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    send(mkword(4'h3, 4'd0, 32'h0));
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(2);
    rst = 1'b1;
    for (int k = 1; k <= 14; k++) push(cyc + k, 1'b1, '0, 1'b1, 1'b0, "midrun_reset_quiet");
    tick(15);
    drain("drain_after_midrun_reset");
    do_compute("compute_zero_operands");
    drain_all("zero_operand_drain");

    tick(5);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries pending, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
